ay_tone_noise: RTL and testbench
================================

// Module: ay_tone_noise
// PURPOSE
//  AY-3-8910-compatible tone and noise generator with mixer; consumer of the prescaler's ~1.789 MHz
//  clock-enable pulse. Produces three mixed 1-bit channel levels (A/B/C) for the downstream volume/DAC
//  stage. Runs entirely in the system clock domain; the prescaler output is used only as an enable.
// PARAMETERS
//  TONE_BITS   12  width of each tone period
//  NOISE_BITS  5   width of noise period
//  TONE_DIV    8   ce pulses per tone tick (full tone period = 2*TONE_DIV*P ce)
//  NOISE_DIV   16  ce pulses per noise tick
// PORTS
//  clk        in  1          system clock; single clock domain
//  reset      in  1          synchronous, active-high
//  ce         in  1          one-clk enable pulse from prescaler; may be held high (fast sim)
//  tone_a/b/c in  TONE_BITS  tone periods, sampled every tick, may change any time
//  noise_per  in  NOISE_BITS noise period
//  mixer      in  6          [2:0] tone disable A..C, [5:3] noise disable A..C (1 = disabled)
//  out_a/b/c  out 1          mixed channel levels, registered
//  noise      out 1          raw noise bit (lfsr[0]), for debug/envelope use
// BEHAVIOUR
//  - Reset (sync, dominates ce): prescale counters 0, tone counters 0, tone squares 0,
//    noise counter 0, lfsr = 17'h00001, out_a/b/c = 0, noise = 1 (lfsr[0]).
//  - Tone tick: 3-bit counter advances on ce; tone_tick asserted on the ce where it wraps
//    TONE_DIV-1 -> 0. Noise tick: 4-bit counter, same rule with NOISE_DIV.
//  - Effective period P = (period==0) ? 1 : period (0 behaves as 1).
//  - Each tone channel on tone_tick: if cnt+1 >= P then cnt<=0, sq<=~sq; else cnt<=cnt+1.
//    Half-period = P tone ticks = TONE_DIV*P ce pulses.
//  - Period lowered below current cnt: the >= compare toggles on the next tone_tick (no wrap
//    through 4095). Raised: counting continues to new P.
//  - Noise on noise_tick: same counter rule with noise_per; on expiry lfsr <= {lfsr[0]^lfsr[3],
//    lfsr[16:1]}. LFSR never all-zero (seed 1, maximal-length taps).
//  - Mixer (registered, every clk, not ce-gated): out_x <= (sq_x | mixer[x]) & (lfsr[0] | mixer[x+3]).
//    All disabled (6'h3F) -> outputs 1, matching AY.
//  - Latency: sq/lfsr update on the clk edge sampling ce; out_x reflects it one clk later.
//  - No ce: all state frozen; mixer changes still propagate in one clk.
//  - Reset mid-operation: all state returns to reset values on that edge; first tone_tick after
//    release occurs on the TONE_DIV-th ce.
// STRUCTURE
//  - Shared header ay_defs.vh: TONE_BITS/NOISE_BITS defaults, mixer bit indices, LFSR seed/taps.
//  - Sub-module ay_tone_channel (counter + square, inputs clk/reset/tick/period, output sq),
//    instantiated 3x. Prescale counters, noise LFSR and mixer live in the top.
// TESTING
//  1 ce held high, tone_a=1, mixer=6'h38 -> out_a toggles every 8 clk (period 16), first rise 9 clk
//    after reset release.
//  2 tone_b=0 vs tone_b=1 -> identical out_b waveforms; tone_c=3 -> out_c half-period 24 ce.
//  3 tone_a=100, change to 2 when cnt=50 -> toggle on next tone_tick, then half-period 16 ce.
//  4 noise_per=1, mixer=6'h07 -> first 4 noise expiries give lfsr 17'h10000,17'h08000,17'h04000,
//    17'h02000; compare 1000 steps vs C/Python model.
//  5 mixer=6'h3F -> out_a/b/c=1 one clk after write regardless of ce; mixer=0 -> AND of sq and noise.
//  6 assert reset for 1 clk mid-tone, realistic ce from prescaler (25 MHz/1.789773 MHz) -> all
//    state at reset values next clk; out_a period = 16*P*13.97 clk avg within 1%.

Source files
------------

// File: rtl/ay_tone_noise_pkg.sv
// Shared constants for the AY tone/noise generator: default widths, mixer bit layout, LFSR.
// Latency: n/a (constants and a pure function).
// Backpressure: n/a.
package ay_tone_noise_pkg;

    localparam int TONE_BITS_DEF  = 12;
    localparam int NOISE_BITS_DEF = 5;

    // Mixer layout: [2:0] tone disables A..C, [5:3] noise disables A..C (1 = disabled).
    localparam int MIX_NOISE_OFS = 3;

    // 17-bit noise shift register, seeded with a single one so it can never lock up at zero.
    localparam int          LFSR_BITS = 17;
    localparam logic [16:0] LFSR_SEED = 17'h00001;
    localparam int          LFSR_TAP  = 3;

    // One noise step: feedback bit0^bit3 enters at the top, register shifts right.
    function automatic logic [LFSR_BITS-1:0] lfsr_step(input logic [LFSR_BITS-1:0] s);
        return {s[0] ^ s[LFSR_TAP], s[LFSR_BITS-1:1]};
    endfunction

endpackage

// File: rtl/ay_tone_channel.sv
// One AY tone channel: period counter plus square-wave flip-flop, advanced on tone ticks.
// Latency: sq updates on the clk edge that samples tick.
// Backpressure: none; tick is a pure enable, period may change at any time.
module ay_tone_channel
    import ay_tone_noise_pkg::*;
#(
    parameter int TONE_BITS = TONE_BITS_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 tick,
    input  logic [TONE_BITS-1:0] period,
    output logic                 sq
);

    logic [TONE_BITS-1:0] cnt_q, cnt_d;
    logic                 sq_q, sq_d;
    logic [TONE_BITS-1:0] per_eff;
    logic [TONE_BITS:0]   cnt_inc;

    // Next-state: a period of 0 acts as 1; >= compare means a lowered period expires at once.
    always_comb begin
        per_eff = (period == '0) ? {{(TONE_BITS-1){1'b0}}, 1'b1} : period;
        cnt_inc = {1'b0, cnt_q} + {{TONE_BITS{1'b0}}, 1'b1};
        cnt_d   = cnt_q;
        sq_d    = sq_q;
        if (tick) begin
            if (cnt_inc >= {1'b0, per_eff}) begin
                cnt_d = '0;
                sq_d  = ~sq_q;
            end else begin
                cnt_d = cnt_inc[TONE_BITS-1:0];
            end
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
            sq_q  <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            sq_q  <= sq_d;
        end
    end

    assign sq = sq_q;

endmodule

// File: rtl/ay_tone_noise.sv
// AY-3-8910 style tone/noise generator and mixer driven by a ~1.79 MHz clock-enable.
// Latency: tone/noise state moves on the edge sampling ce; mixed outputs follow one clk later.
// Backpressure: none; without ce all state holds, mixer changes still reach outputs in one clk.
module ay_tone_noise
    import ay_tone_noise_pkg::*;
#(
    parameter int TONE_BITS  = TONE_BITS_DEF,
    parameter int NOISE_BITS = NOISE_BITS_DEF,
    parameter int TONE_DIV   = 8,
    parameter int NOISE_DIV  = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ce,
    input  logic [TONE_BITS-1:0]  tone_a,
    input  logic [TONE_BITS-1:0]  tone_b,
    input  logic [TONE_BITS-1:0]  tone_c,
    input  logic [NOISE_BITS-1:0] noise_per,
    input  logic [5:0]            mixer,
    output logic                  out_a,
    output logic                  out_b,
    output logic                  out_c,
    output logic                  noise
);

    localparam int                TDIV_W    = $clog2(TONE_DIV);
    localparam int                NDIV_W    = $clog2(NOISE_DIV);
    localparam logic [TDIV_W-1:0] TDIV_LAST = TDIV_W'(TONE_DIV - 1);
    localparam logic [NDIV_W-1:0] NDIV_LAST = NDIV_W'(NOISE_DIV - 1);

    logic [TDIV_W-1:0]     tdiv_q, tdiv_d;
    logic [NDIV_W-1:0]     ndiv_q, ndiv_d;
    logic                  tone_tick, noise_tick;
    logic [NOISE_BITS-1:0] ncnt_q, ncnt_d;
    logic [NOISE_BITS-1:0] nper_eff;
    logic [NOISE_BITS:0]   ncnt_inc;
    logic [LFSR_BITS-1:0]  lfsr_q, lfsr_d;
    logic [2:0]            out_q, out_d;
    logic [2:0]            sq;
    logic [3*TONE_BITS-1:0] periods;

    assign periods = {tone_c, tone_b, tone_a};

    // Prescalers: tick fires on the ce that wraps the counter from DIV-1 back to 0.
    always_comb begin
        tone_tick  = ce && (tdiv_q == TDIV_LAST);
        noise_tick = ce && (ndiv_q == NDIV_LAST);
        tdiv_d     = tdiv_q;
        ndiv_d     = ndiv_q;
        if (ce) begin
            tdiv_d = tone_tick  ? '0 : tdiv_q + {{(TDIV_W-1){1'b0}}, 1'b1};
            ndiv_d = noise_tick ? '0 : ndiv_q + {{(NDIV_W-1){1'b0}}, 1'b1};
        end
    end

    // Noise period counter; each expiry steps the LFSR once.
    always_comb begin
        nper_eff = (noise_per == '0) ? {{(NOISE_BITS-1){1'b0}}, 1'b1} : noise_per;
        ncnt_inc = {1'b0, ncnt_q} + {{NOISE_BITS{1'b0}}, 1'b1};
        ncnt_d   = ncnt_q;
        lfsr_d   = lfsr_q;
        if (noise_tick) begin
            if (ncnt_inc >= {1'b0, nper_eff}) begin
                ncnt_d = '0;
                lfsr_d = lfsr_step(lfsr_q);
            end else begin
                ncnt_d = ncnt_inc[NOISE_BITS-1:0];
            end
        end
    end

    // Mixer: a disable bit forces that source to 1, so all-disabled gives a constant high.
    always_comb begin
        out_d = '0;
        for (int i = 0; i < 3; i++) begin
            out_d[i] = (sq[i] | mixer[i]) & (lfsr_q[0] | mixer[i + MIX_NOISE_OFS]);
        end
    end

    // State registers; reset dominates ce.
    always_ff @(posedge clk) begin
        if (reset) begin
            tdiv_q <= '0;
            ndiv_q <= '0;
            ncnt_q <= '0;
            lfsr_q <= LFSR_SEED;
            out_q  <= '0;
        end else begin
            tdiv_q <= tdiv_d;
            ndiv_q <= ndiv_d;
            ncnt_q <= ncnt_d;
            lfsr_q <= lfsr_d;
            out_q  <= out_d;
        end
    end

    for (genvar g = 0; g < 3; g++) begin : g_chan
        ay_tone_channel #(
            .TONE_BITS (TONE_BITS)
        ) u_chan (
            .clk    (clk),
            .reset  (reset),
            .tick   (tone_tick),
            .period (periods[g*TONE_BITS +: TONE_BITS]),
            .sq     (sq[g])
        );
    end

    assign out_a = out_q[0];
    assign out_b = out_q[1];
    assign out_c = out_q[2];
    assign noise = lfsr_q[0];

endmodule

// File: tb/tb_ay_tone_noise.sv
// Bench for ay_tone_noise: directed stimulus pushes expected outputs into a scoreboard queue,
// a negedge monitor pops and compares them against {noise, out_c, out_b, out_a}.
// Measured quantities (ce counts, periods) go through a second queue checked against a range.
module tb_ay_tone_noise;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        ce = 1'b0;
    logic [11:0] tone_a = '0, tone_b = '0, tone_c = '0;
    logic [4:0]  noise_per = '0;
    logic [5:0]  mixer = '0;
    logic        out_a, out_b, out_c, noise;
    logic [3:0]  obs;

    typedef struct {
        int         cyc;
        logic [3:0] val;
        logic [3:0] mask;
        int         test;
        int         idx;
    } exp_t;

    typedef struct {
        int test;
        int act;
        int lo;
        int hi;
    } meas_t;

    exp_t  exp_q[$];
    meas_t meas_q[$];
    exp_t  e;
    meas_t m;

    int n_checks = 0;
    int n_err    = 0;
    int cyc      = 0;
    int cec      = 0;
    int ce_mode  = 0;
    int cur_test = 0;
    int idx      = 0;
    int acc      = 0;

    ay_tone_noise dut (
        .clk       (clk),
        .reset     (reset),
        .ce        (ce),
        .tone_a    (tone_a),
        .tone_b    (tone_b),
        .tone_c    (tone_c),
        .noise_per (noise_per),
        .mixer     (mixer),
        .out_a     (out_a),
        .out_b     (out_b),
        .out_c     (out_c),
        .noise     (noise)
    );

    assign obs = {noise, out_c, out_b, out_a};

    always #5 clk = ~clk;

    // Cycle and ce-pulse counters.
    always @(posedge clk) begin
        cyc++;
        if (ce) cec++;
    end

    // ce source: off, held high, or a 25 MHz -> 1.789773 MHz fractional prescaler.
    always @(posedge clk) begin
        #2;
        case (ce_mode)
            0: ce = 1'b0;
            1: ce = 1'b1;
            default: begin
                acc += 1789773;
                if (acc >= 25000000) begin
                    acc -= 25000000;
                    ce = 1'b1;
                end else begin
                    ce = 1'b0;
                end
            end
        endcase
    end

    // Monitor: compare every expectation due this cycle, and every posted measurement.
    always @(negedge clk) begin
        while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
            e = exp_q.pop_front();
            n_checks++;
            if (e.cyc < cyc || ((obs ^ e.val) & e.mask) != 4'h0) begin
                n_err++;
                $display("FAIL t%0d[%0d] cyc %0d: got {noise,c,b,a}=%b want %b (mask %b)",
                         e.test, e.idx, e.cyc, obs, e.val, e.mask);
            end
        end
        while (meas_q.size() > 0) begin
            m = meas_q.pop_front();
            n_checks++;
            if (m.act < m.lo || m.act > m.hi) begin
                n_err++;
                $display("FAIL t%0d meas: got %0d want %0d..%0d", m.test, m.act, m.lo, m.hi);
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic expect_at(input int dly, input logic [3:0] v, input logic [3:0] mk);
        exp_q.push_back('{cyc + dly, v, mk, cur_test, idx});
        idx++;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step(1);
        expect_at(0, 4'b1000, 4'hF);
        reset = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_q.size() > 0 || meas_q.size() > 0) && n < 3000) begin
            step(1);
            n++;
        end
        if (exp_q.size() > 0) begin
            meas_q.push_back('{cur_test, -1, 0, 0});
            exp_q.delete();
            step(2);
        end
    endtask

    logic [16:0] lm;
    logic        a, b, c, prev, found;
    int          base, t0, rises;
    logic [5:0]  mix_v [6];
    logic [3:0]  mix_e [6];

    initial begin
        step(2);

        // 1/2: ce high, A period 1, B period 0 (acts as 1), C period 3, noise disabled.
        cur_test = 1; idx = 0;
        ce_mode = 1; tone_a = 12'd1; tone_b = 12'd0; tone_c = 12'd3;
        noise_per = 5'd1; mixer = 6'h38;
        do_reset();
        for (int k = 1; k <= 60; k++) begin
            a = 1'(((k - 1) / 8) % 2);
            c = 1'(((k - 1) / 24) % 2);
            expect_at(k, {1'b0, c, a, a}, 4'b0111);
        end
        step(61);
        drain();

        // 3: period 100 lowered to 2 once the counter has passed it.
        cur_test = 3; idx = 0;
        tone_a = 12'd100;
        do_reset();
        expect_at(400, 4'b0000, 4'b0001);
        expect_at(408, 4'b0000, 4'b0001);
        expect_at(409, 4'b0001, 4'b0001);
        expect_at(424, 4'b0001, 4'b0001);
        expect_at(425, 4'b0000, 4'b0001);
        expect_at(440, 4'b0000, 4'b0001);
        expect_at(441, 4'b0001, 4'b0001);
        step(404);
        tone_a = 12'd2;
        step(40);
        drain();

        // 4: noise period 1, tones disabled; every channel and noise follow lfsr[0].
        cur_test = 4; idx = 0;
        mixer = 6'h07; noise_per = 5'd1;
        do_reset();
        lm = 17'h00001;
        for (int k = 1; k <= 1000; k++) begin
            lm = {lm[0] ^ lm[3], lm[16:1]};
            expect_at(16 * k + 1, {4{lm[0]}}, 4'hF);
        end
        step(16 * 1000 + 2);
        drain();

        // 5: build sq=111, lfsr[0]=0, stop ce, then walk mixer settings.
        cur_test = 5; idx = 0;
        tone_a = 12'd1; tone_b = 12'd3; tone_c = 12'd1; noise_per = 5'd0; mixer = 6'h00;
        do_reset();
        step(24);
        ce_mode = 0;
        mix_v[0] = 6'h00; mix_e[0] = 4'b0000;
        mix_v[1] = 6'h38; mix_e[1] = 4'b0111;
        mix_v[2] = 6'h08; mix_e[2] = 4'b0001;
        mix_v[3] = 6'h3F; mix_e[3] = 4'b0111;
        mix_v[4] = 6'h07; mix_e[4] = 4'b0000;
        mix_v[5] = 6'h20; mix_e[5] = 4'b0100;
        for (int i = 0; i < 6; i++) begin
            mixer = mix_v[i];
            expect_at(1, mix_e[i], 4'hF);
            step(1);
        end
        mixer = 6'h38;
        for (int k = 1; k <= 40; k += 3) expect_at(k, 4'b0111, 4'hF);
        step(41);
        drain();

        // 6: realistic ce, reset mid-tone, first rise after 16 ce, then 8 periods timed.
        cur_test = 6; idx = 0;
        ce_mode = 2; tone_a = 12'd2; tone_b = 12'd5; tone_c = 12'd7;
        noise_per = 5'd1; mixer = 6'h38;
        do_reset();
        step(300);
        do_reset();
        base = cec;
        found = 1'b0;
        for (int i = 0; i < 2000 && !found; i++) begin
            step(1);
            if (out_a) found = 1'b1;
        end
        meas_q.push_back('{6, found ? cec - base : -1, 16, 16});
        t0 = cyc; rises = 0; prev = 1'b1;
        for (int i = 0; i < 6000 && rises < 8; i++) begin
            step(1);
            if (out_a && !prev) rises++;
            prev = out_a;
        end
        meas_q.push_back('{6, (rises == 8) ? cyc - t0 : -1, 3540, 3611});
        step(2);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
